// File: rtl/hex_digit_counter.sv
// Four-digit up/down counter stepped by a programmable rate divider, feeding 7-segment decoders.
// Define HEX_DIGIT_COUNTER_BCD_EN for decimal digits (0-9); default build counts hex digits (0-F).
module hex_digit_counter #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] digits,
  output logic        tick,
  output logic        carry
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] RELOAD = DW'(DIV - 1);

`ifdef HEX_DIGIT_COUNTER_BCD_EN
  localparam logic [3:0] DMAX = 4'd9;
`else
  localparam logic [3:0] DMAX = 4'hF;
`endif

  logic [DW-1:0] divider;
  logic [15:0]   next_digits;
  logic [15:0]   load_digits;
  logic          wrap;
  logic          step;

  assign step = enable && !load && (divider == '0);

  // Ripple the carry/borrow through all four digits in one cycle; a carry out
  // of the top digit is the full-range wrap.
  always_comb begin
    logic c;
    next_digits = digits;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (up_down) begin
          if (digits[4*i +: 4] == DMAX) begin
            next_digits[4*i +: 4] = 4'd0;
          end else begin
            next_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (digits[4*i +: 4] == 4'd0) begin
            next_digits[4*i +: 4] = DMAX;
          end else begin
            next_digits[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    wrap = c;
  end

  always_comb begin
    load_digits = load_value;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    for (int i = 0; i < 4; i++) begin
      if (load_value[4*i +: 4] > DMAX) load_digits[4*i +: 4] = DMAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      digits  <= 16'h0000;
      divider <= RELOAD;
      tick    <= 1'b0;
      carry   <= 1'b0;
    end else if (load) begin
      digits  <= load_digits;
      divider <= RELOAD;
      tick    <= 1'b0;
      carry   <= 1'b0;
    end else if (step) begin
      digits  <= next_digits;
      divider <= RELOAD;
      tick    <= 1'b1;
      carry   <= wrap;
    end else begin
      if (enable) divider <= divider - DW'(1);
      tick  <= 1'b0;
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Randomized and directed bench for hex_digit_counter (DIV=4); the reference model
// treats the digits as one integer counted modulo the full range.
module tb_hex_digit_counter;

  localparam int DIV = 4;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
  localparam int RANGE = 10000;
`else
  localparam int RANGE = 65536;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [15:0] digits;
  logic        tick;
  logic        carry;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_val = 0;
  int m_cnt = 0;
  bit m_tick = 1'b0;
  bit m_carry = 1'b0;

  hex_digit_counter #(.DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .digits(digits), .tick(tick), .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input int v);
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
    return 16'(v);
`endif
  endfunction

  function automatic int dec_load(input logic [15:0] lv);
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v += n * w;
      w *= 10;
    end
    return v;
`else
    return int'(lv);
`endif
  endfunction

  function automatic logic [17:0] expv();
    return {enc(m_val), m_tick, m_carry};
  endfunction

  // Drive one cycle of inputs, advance the model over the edge, settle past it.
  task automatic cycle(input bit rn, input bit en, input bit ud, input bit ld,
                       input logic [15:0] lv);
    resetn = rn; enable = en; up_down = ud; load = ld; load_value = lv;
    @(posedge clk);
    m_tick = 1'b0;
    m_carry = 1'b0;
    if (!rn) begin
      m_val = 0; m_cnt = 0;
    end else if (ld) begin
      m_val = dec_load(lv); m_cnt = 0;
    end else if (en) begin
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_tick = 1'b1;
        if (ud) begin
          m_carry = (m_val == RANGE - 1);
          m_val = (m_val + 1) % RANGE;
        end else begin
          m_carry = (m_val == 0);
          m_val = (m_val + RANGE - 1) % RANGE;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);
    checks++;
    if ({digits, tick, carry} !== 18'h0) begin
      errors++;
      $display("FAIL reset got %h/%b/%b exp 0000/0/0", digits, tick, carry);
    end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 16 * DIV; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      checks++;
      if ({digits, tick, carry} !== expv()) begin
        errors++;
        $display("FAIL count_up c%0d got %h exp %h", i, {digits, tick, carry}, expv());
      end
      if (i == DIV) begin
        checks++;
        if (digits !== 16'h0001 || tick !== 1'b1) begin
          errors++;
          $display("FAIL first_tick got %h/%b exp 0001/1", digits, tick);
        end
      end
    end
    checks++;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    if (digits !== 16'h0016) begin
      errors++; $display("FAIL sixteen_steps got %h exp 0016", digits);
    end
`else
    if (digits !== 16'h0010) begin
      errors++; $display("FAIL sixteen_steps got %h exp 0010", digits);
    end
`endif
  endtask

  task automatic test_wrap_up();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 1; i <= 2 * DIV; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      checks++;
      if ({digits, tick, carry} !== expv()) begin
        errors++;
        $display("FAIL wrap_up c%0d got %h exp %h", i, {digits, tick, carry}, expv());
      end
    end
    checks++;
    if (digits !== 16'h0001 || carry !== 1'b0) begin
      errors++; $display("FAIL wrap_up_next got %h/%b exp 0001/0", digits, carry);
    end
  endtask

  task automatic test_down();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
    for (int i = 0; i < DIV; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    if (digits !== 16'h0099 || tick !== 1'b1 || carry !== 1'b0) begin
      errors++; $display("FAIL down_borrow got %h/%b/%b exp 0099/1/0", digits, tick, carry);
    end
`else
    if (digits !== 16'h00FF || tick !== 1'b1 || carry !== 1'b0) begin
      errors++; $display("FAIL down_borrow got %h/%b/%b exp 00ff/1/0", digits, tick, carry);
    end
`endif
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < DIV; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
    if ({digits, tick, carry} !== {enc(RANGE - 1), 2'b11}) begin
      errors++;
      $display("FAIL down_wrap got %h/%b/%b exp %h/1/1", digits, tick, carry, enc(RANGE - 1));
    end
  endtask

  task automatic test_enable_hold();
    int step_at = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0005);
    for (int i = 1; i <= DIV + 3; i++) begin
      if (i >= 3 && i <= 5) cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      else cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      if (tick === 1'b1 && step_at == 0) step_at = i;
      checks++;
      if ({digits, tick, carry} !== expv()) begin
        errors++;
        $display("FAIL enable_hold c%0d got %h exp %h", i, {digits, tick, carry}, expv());
      end
    end
    checks++;
    if (step_at != DIV + 3 || digits !== 16'h0006) begin
      errors++;
      $display("FAIL enable_delay got step at %0d digits %h exp step at %0d digits 0006",
               step_at, digits, DIV + 3);
    end
    // bring divider to zero, then load on the edge that would have stepped
    for (int i = 0; i < DIV - 1; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    checks++;
    if ({digits, tick, carry} !== {16'h1234, 2'b00}) begin
      errors++;
      $display("FAIL load_priority got %h/%b/%b exp 1234/0/0", digits, tick, carry);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++;
    if (tick !== 1'b0 || digits !== 16'h1234) begin
      errors++; $display("FAIL load_reload got %h/%b exp 1234/0", digits, tick);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= DIV; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      checks++;
      if (tick !== (i == DIV) || digits !== ((i == DIV) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL reset_mid c%0d got %h/%b exp tick %0d", i, digits, tick, i == DIV);
      end
    end
  endtask

`ifdef HEX_DIGIT_COUNTER_BCD_EN
  task automatic test_bcd();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h000A);
    checks++;
    if (digits !== 16'h0009) begin
      errors++; $display("FAIL bcd_clamp got %h exp 0009", digits);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0099);
    for (int i = 0; i < DIV; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++;
    if (digits !== 16'h0100 || tick !== 1'b1) begin
      errors++; $display("FAIL bcd_ripple got %h/%b exp 0100/1", digits, tick);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, 16'($urandom));
      checks++;
      if ({digits, tick, carry} !== expv()) begin
        errors++;
        $display("FAIL random c%0d got %h exp %h", i, {digits, tick, carry}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_down();
    test_enable_hold();
    test_reset_mid();
`ifdef HEX_DIGIT_COUNTER_BCD_EN
    test_bcd();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
